imem_loader: RTL

Writer-side counterpart to the fetch stage's instruction-memory read port. Accepts a stream of 16-bit halfwords over a valid/ready handshake, assembles them into 32-bit instruction words, and writes them sequentially into instruction memory starting at BASE_ADDR. Holds the processor in reset (o_cpu_hold) until the load completes, then releases it. Sits between the external input port and the instruction-memory write port, beside the processor top.

---
 rtl/imem_loader.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: receives a header halfword N followed by N pairs of
// {upper, lower} instruction halves over a valid/ready handshake, packs
// each pair into a 32-bit word and writes the words sequentially into
// instruction memory from BASE_ADDR. The processor is held in reset
// while a load is in progress and released once the session completes.
module imem_loader #(
  parameter int ADDR_WIDTH    = 12,
  parameter int DEPTH         = 4096,
  parameter int BASE_ADDR     = 0,
  parameter int HOLD_AT_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [15:0]           i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [31:0]           o_mem_wdata,
  output logic                  o_cpu_hold,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic [15:0]           o_count
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    HI   = 3'd2,
    LO   = 3'd3,
    WR   = 3'd4,
    FIN  = 3'd5
  } loaderState_t;

  // Number of words that fit between BASE_ADDR and the top of memory.
  // Kept one bit wider than the header so a full 64K-word memory still
  // compares correctly.
  localparam logic [16:0]           CAPACITY = 17'(DEPTH - BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
  localparam logic                  HOLD_RST = (HOLD_AT_RESET != 0);

  loaderState_t state_r;
  logic [15:0]  numWords_r;
  logic [15:0]  hiHalf_r;

  logic         xfer_s;
  logic         hdrTooBig_s;
  logic         lastWord_s;

  // Handshake decode and end-of-session/capacity comparisons.
  always_comb begin
    xfer_s      = i_valid && o_ready;
    hdrTooBig_s = ({1'b0, i_data} > CAPACITY);
    lastWord_s  = ((o_count + 16'd1) == numWords_r);
  end

  // Session FSM; every output is registered and updated on state transitions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      numWords_r  <= 16'd0;
      hiHalf_r    <= 16'd0;
      o_ready     <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= BASE;
      o_mem_wdata <= 32'd0;
      o_cpu_hold  <= HOLD_RST;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      o_count     <= 16'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (i_start) begin
            state_r    <= HDR;
            o_ready    <= 1'b1;
            o_busy     <= 1'b1;
            o_cpu_hold <= 1'b1;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
            o_count    <= 16'd0;
            o_mem_addr <= BASE;
          end else begin
            state_r <= IDLE;
          end
        end

        HDR: begin
          if (xfer_s) begin
            if (i_data == 16'd0) begin
              state_r <= FIN;
              o_ready <= 1'b0;
            end else if (hdrTooBig_s) begin
              // Reject the whole session up front so memory is never
              // partially overwritten by an oversized image.
              state_r <= FIN;
              o_ready <= 1'b0;
              o_err   <= 1'b1;
            end else begin
              numWords_r <= i_data;
              state_r    <= HI;
            end
          end else begin
            state_r <= HDR;
          end
        end

        HI: begin
          if (xfer_s) begin
            hiHalf_r <= i_data;
            state_r  <= LO;
          end else begin
            state_r <= HI;
          end
        end

        LO: begin
          if (xfer_s) begin
            // Write data is only updated here so it stays stable while
            // the write enable is low.
            o_mem_wdata <= {hiHalf_r, i_data};
            o_mem_we    <= 1'b1;
            o_ready     <= 1'b0;
            state_r     <= WR;
          end else begin
            state_r <= LO;
          end
        end

        WR: begin
          o_mem_we <= 1'b0;
          o_count  <= o_count + 16'd1;
          if (lastWord_s) begin
            state_r <= FIN;
          end else begin
            o_mem_addr <= o_mem_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            o_ready    <= 1'b1;
            state_r    <= HI;
          end
        end

        FIN: begin
          o_busy     <= 1'b0;
          o_done     <= 1'b1;
          o_cpu_hold <= 1'b0;
          state_r    <= IDLE;
        end

        default: begin
          state_r  <= IDLE;
          o_ready  <= 1'b0;
          o_mem_we <= 1'b0;
          o_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule
